// File: rtl/ledmux_frame_scheduler.sv
// LED-matrix frame scheduler: queues display command bytes, shows each for a
// programmed dwell, and generates the scroll frame tick and scroll position.
module ledmux_frame_scheduler #(
  parameter int         DEPTH        = 4,
  parameter int         PRESCALE     = 4194304,
  parameter int         DWELL_FRAMES = 16,
  parameter logic [7:0] DEFAULT_VAL  = 8'h21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_data,
  output logic                     cmd_ready,
  output logic [7:0]               val_out,
  output logic [3:0]               scroll_pos,
  output logic                     frame_tick,
  output logic                     busy,
  output logic                     cmd_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  // state | meaning
  // IDLE  | nothing to show, val_out holds the last value
  // LOAD  | pop FIFO head into val_out and arm the dwell counter
  // HOLD  | current command displayed, dwell counts down on frame ticks

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(8 * DWELL_FRAMES) + 1;

  localparam logic [AW:0]   FULL_LVL   = (AW + 1)'(DEPTH);
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DWELL_UNIT = DW'(DWELL_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            load;
  logic            done_nxt;
  logic [PW-1:0]   pre_cnt;
  logic [DW-1:0]   dwell_cnt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      head;
  logic            push, pop;

  // Prescaler
  assign frame_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pre_cnt <= '0;
    else if (frame_tick) pre_cnt <= '0;
    else                 pre_cnt <= pre_cnt + 1'b1;
  end

  // Command FIFO; a pop while full leaves cmd_ready low until the count drops.
  assign cmd_ready = (fifo_level != FULL_LVL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = load;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (frame_tick && dwell_cnt == DW'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = (fifo_level != '0) ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_out    <= DEFAULT_VAL;
      dwell_cnt  <= '0;
      scroll_pos <= '0;
      cmd_done   <= 1'b0;
    end else begin
      cmd_done <= done_nxt;
      if (load) begin
        val_out    <= {2'b00, head[5:0]};
        dwell_cnt  <= DWELL_UNIT << head[7:6];
        scroll_pos <= '0;
      end else begin
        if (frame_tick) scroll_pos <= scroll_pos + 1'b1;
        // terminal-count compare at 1 stops the count at 0, never below
        if (state == HOLD && frame_tick && dwell_cnt != '0)
          dwell_cnt <= dwell_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ledmux_frame_scheduler.sv
// Directed bench for ledmux_frame_scheduler with a short prescaler and dwell.
module tb_ledmux_frame_scheduler;

  localparam int DEPTH        = 4;
  localparam int PRESCALE     = 4;
  localparam int DWELL_FRAMES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] val_out;
  logic [3:0] scroll_pos;
  logic       frame_tick;
  logic       busy;
  logic       cmd_done;
  logic [$clog2(DEPTH):0] fifo_level;

  int n_checks = 0;
  int n_fails  = 0;

  ledmux_frame_scheduler #(
    .DEPTH(DEPTH), .PRESCALE(PRESCALE), .DWELL_FRAMES(DWELL_FRAMES), .DEFAULT_VAL(8'h21)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .val_out(val_out), .scroll_pos(scroll_pos),
    .frame_tick(frame_tick), .busy(busy), .cmd_done(cmd_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at the negedge of the first HOLD cycle; returns at the cmd_done cycle.
  task automatic wait_done(input string tag, output logic [7:0] v, output int ticks,
                           output logic b, output logic [3:0] sp);
    logic found;
    found = 1'b0;
    ticks = 0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_done) begin
        found = 1'b1;
        break;
      end
      if (frame_tick) ticks++;
      @(negedge clk);
    end
    check({tag, " done seen"}, 32'(found), 32'd1);
    v  = val_out;
    b  = busy;
    sp = scroll_pos;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic       b;
    logic [3:0] sp;
    int         ticks;
    int         pre_ticks;
    int         last;
    int         n_done;
    int         n_busy;
    logic [3:0] exp_pos;
    logic       found;
    logic [7:0] bp_bytes [5];

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    repeat (2) @(negedge clk);

    check("reset val_out", 32'(val_out), 32'h21);
    check("reset scroll_pos", 32'(scroll_pos), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    check("reset frame_tick", 32'(frame_tick), 32'd0);
    check("reset cmd_done", 32'(cmd_done), 32'd0);

    // prescaler: counts 1,2,3 after release, tick while 3, then wraps
    reset = 1'b0;
    @(negedge clk); check("pre tick c1", 32'(frame_tick), 32'd0);
    @(negedge clk); check("pre tick c2", 32'(frame_tick), 32'd0);
    @(negedge clk); check("pre tick c3", 32'(frame_tick), 32'd1);
    @(negedge clk); check("pre tick c4", 32'(frame_tick), 32'd0);
    check("pre scroll inc", 32'(scroll_pos), 32'd1);

    // single command 8'h45: dwell code 1 -> 4 frames
    cmd_valid = 1'b1; cmd_data = 8'h45;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("single lvl after push", 32'(fifo_level), 32'd1);
    check("single idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("single load busy", 32'(busy), 32'd1);
    check("single load val old", 32'(val_out), 32'h21);
    @(negedge clk);
    check("single val", 32'(val_out), 32'h05);
    check("single lvl popped", 32'(fifo_level), 32'd0);
    check("single scroll zero", 32'(scroll_pos), 32'd0);
    wait_done("single", v, ticks, b, sp);
    check("single ticks", 32'(ticks), 32'd4);
    check("single done val", 32'(v), 32'h05);
    check("single done busy", 32'(b), 32'd0);
    check("single done scroll", 32'(sp), 32'd4);
    @(negedge clk);
    check("single done pulse", 32'(cmd_done), 32'd0);
    check("single idle val kept", 32'(val_out), 32'h05);

    // back-to-back 8'h01 then 8'h20: no IDLE between them
    cmd_valid = 1'b1; cmd_data = 8'h01;
    @(negedge clk);
    cmd_data = 8'h20;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b first val", 32'(val_out), 32'h01);
    check("b2b lvl", 32'(fifo_level), 32'd1);
    wait_done("b2b first", v, ticks, b, sp);
    check("b2b first ticks", 32'(ticks), 32'd2);
    check("b2b first done val", 32'(v), 32'h01);
    check("b2b no idle", 32'(b), 32'd1);
    @(negedge clk);
    check("b2b second val", 32'(val_out), 32'h20);
    check("b2b scroll restart", 32'(scroll_pos), 32'd0);
    check("b2b busy", 32'(busy), 32'd1);
    wait_done("b2b second", v, ticks, b, sp);
    check("b2b second ticks", 32'(ticks), 32'd2);
    check("b2b second idle", 32'(b), 32'd0);

    // backpressure: 8'hC7 holds 16 frames while five bytes are offered
    cmd_valid = 1'b1; cmd_data = 8'hC7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp hold val", 32'(val_out), 32'h07);
    bp_bytes[0] = 8'h41; bp_bytes[1] = 8'h02; bp_bytes[2] = 8'h03;
    bp_bytes[3] = 8'h04; bp_bytes[4] = 8'h3F;
    pre_ticks = 0;
    for (int i = 0; i < 5; i++) begin
      if (frame_tick) pre_ticks++;
      cmd_valid = 1'b1; cmd_data = bp_bytes[i];
      @(negedge clk);
      check("bp level", 32'(fifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    cmd_valid = 1'b0;
    check("bp ready low", 32'(cmd_ready), 32'd0);
    wait_done("bp c7", v, ticks, b, sp);
    check("bp c7 ticks", 32'(ticks + pre_ticks), 32'd16);
    check("bp c7 val", 32'(v), 32'h07);
    check("bp c7 next load", 32'(b), 32'd1);
    check("bp pop no ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("bp 41 val", 32'(val_out), 32'h01);
    check("bp lvl 3", 32'(fifo_level), 32'd3);
    check("bp ready back", 32'(cmd_ready), 32'd1);
    wait_done("bp 41", v, ticks, b, sp);
    check("bp 41 ticks", 32'(ticks), 32'd4);
    @(negedge clk);
    check("bp 02 val", 32'(val_out), 32'h02);
    wait_done("bp 02", v, ticks, b, sp);
    check("bp 02 ticks", 32'(ticks), 32'd2);
    @(negedge clk);
    check("bp 03 val", 32'(val_out), 32'h03);
    wait_done("bp 03", v, ticks, b, sp);
    @(negedge clk);
    check("bp 04 val", 32'(val_out), 32'h04);
    wait_done("bp 04", v, ticks, b, sp);
    check("bp 04 idle", 32'(b), 32'd0);
    check("bp drained", 32'(fifo_level), 32'd0);
    repeat (10) @(negedge clk);
    check("bp 3f dropped", 32'(val_out), 32'h04);
    check("bp stays idle", 32'(busy), 32'd0);

    // wrap: 8'hC0 dwells 16 frames, scroll_pos 0..15 then 0
    cmd_valid = 1'b1; cmd_data = 8'hC0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wrap val", 32'(val_out), 32'h00);
    exp_pos = 4'd0;
    ticks   = 0;
    last    = -1;
    found   = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cmd_done) begin
        found = 1'b1;
        break;
      end
      if (frame_tick) begin
        check("wrap pos", 32'(scroll_pos), 32'(exp_pos));
        if (last >= 0) check("wrap tick gap", 32'(cyc - last), 32'd4);
        last = cyc;
        exp_pos = exp_pos + 4'd1;
        ticks++;
      end
      @(negedge clk);
    end
    check("wrap done seen", 32'(found), 32'd1);
    check("wrap ticks", 32'(ticks), 32'd16);
    check("wrap pos zero", 32'(scroll_pos), 32'd0);

    // reset mid-HOLD with two queued
    cmd_valid = 1'b1; cmd_data = 8'hC1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'h02;
    @(negedge clk);
    cmd_data = 8'h03;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst pre lvl", 32'(fifo_level), 32'd2);
    check("rst pre busy", 32'(busy), 32'd1);
    check("rst pre val", 32'(val_out), 32'h01);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst async lvl", 32'(fifo_level), 32'd0);
    check("rst async val", 32'(val_out), 32'h21);
    check("rst async busy", 32'(busy), 32'd0);
    check("rst async ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_done) n_done++;
      if (busy) n_busy++;
    end
    check("rst no cmd_done", 32'(n_done), 32'd0);
    check("rst no busy", 32'(n_busy), 32'd0);
    check("rst lvl after", 32'(fifo_level), 32'd0);
    check("rst val after", 32'(val_out), 32'h21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
